// File: rtl/rs_scoreboard.sv
// Register scoreboard: per-register outstanding-write counters that hold an
// instruction at issue on RAW hazards or a saturated destination counter.
module rs_scoreboard #(
    parameter int CNT_W     = 2,
    parameter int WB_BYPASS = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        issue_valid,
    output logic        issue_ready,
    input  logic [4:0]  issue_rs1,
    input  logic [4:0]  issue_rs2,
    input  logic        issue_uses_rs1,
    input  logic        issue_uses_rs2,
    input  logic [4:0]  issue_rd,
    input  logic        issue_rd_we,
    input  logic        wb_valid,
    input  logic [4:0]  wb_rd,
    input  logic        flush,
    output logic [31:0] busy_vec,
    output logic        stall,
    output logic        err_underflow
);

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    logic [CNT_W-1:0] cnt [32];

    logic [CNT_W-1:0] rs1_cnt;
    logic [CNT_W-1:0] rs2_cnt;
    logic [CNT_W-1:0] rd_cnt;
    logic [CNT_W-1:0] wb_cnt;
    logic             rs1_release;
    logic             rs2_release;
    logic             haz1;
    logic             haz2;
    logic             waw_full;
    logic             fire;
    logic [31:0]      inc_vec;
    logic [31:0]      dec_vec;

    always_comb begin
        rs1_cnt = cnt[issue_rs1];
        rs2_cnt = cnt[issue_rs2];
        rd_cnt  = cnt[issue_rd];
        wb_cnt  = cnt[wb_rd];

        // A final writeback landing this cycle releases the source early
        rs1_release = (WB_BYPASS != 0) && wb_valid && (wb_rd == issue_rs1) && (rs1_cnt == CNT_ONE);
        rs2_release = (WB_BYPASS != 0) && wb_valid && (wb_rd == issue_rs2) && (rs2_cnt == CNT_ONE);

        haz1     = issue_uses_rs1 && (issue_rs1 != 5'd0) && (rs1_cnt != '0) && !rs1_release;
        haz2     = issue_uses_rs2 && (issue_rs2 != 5'd0) && (rs2_cnt != '0) && !rs2_release;
        waw_full = issue_rd_we && (issue_rd != 5'd0) && (rd_cnt == CNT_MAX);

        issue_ready = !flush && !haz1 && !haz2 && !waw_full;
        stall       = issue_valid && !issue_ready;
        fire        = issue_valid && issue_ready;
    end

    always_comb begin
        inc_vec = '0;
        dec_vec = '0;
        busy_vec = '0;
        for (int r = 1; r < 32; r++) begin
            inc_vec[r]  = fire && issue_rd_we && (issue_rd == 5'(r));
            dec_vec[r]  = wb_valid && (wb_rd == 5'(r)) && (cnt[r] != '0);
            busy_vec[r] = (cnt[r] != '0);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int r = 0; r < 32; r++) begin
                cnt[r] <= '0;
            end
            err_underflow <= 1'b0;
        end else begin
            for (int r = 0; r < 32; r++) begin
                if (flush || r == 0) begin
                    cnt[r] <= '0;
                end else if (inc_vec[r] && !dec_vec[r]) begin
                    cnt[r] <= cnt[r] + CNT_ONE;
                end else if (dec_vec[r] && !inc_vec[r]) begin
                    cnt[r] <= cnt[r] - CNT_ONE;
                end
            end
            if (wb_valid && (wb_rd != 5'd0) && (wb_cnt == '0)) begin
                err_underflow <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_rs_scoreboard.sv
// Directed, table-driven bench for rs_scoreboard with default parameters
// (CNT_W=2, WB_BYPASS=1), plus a hand sequence for asynchronous reset.
module tb_rs_scoreboard;

    logic        clk;
    logic        rst_n;
    logic        issue_valid;
    logic        issue_ready;
    logic [4:0]  issue_rs1;
    logic [4:0]  issue_rs2;
    logic        issue_uses_rs1;
    logic        issue_uses_rs2;
    logic [4:0]  issue_rd;
    logic        issue_rd_we;
    logic        wb_valid;
    logic [4:0]  wb_rd;
    logic        flush;
    logic [31:0] busy_vec;
    logic        stall;
    logic        err_underflow;

    int checks;
    int failures;

    typedef struct {
        logic        v;
        logic [4:0]  rs1;
        logic        u1;
        logic [4:0]  rs2;
        logic        u2;
        logic [4:0]  rd;
        logic        we;
        logic        wbv;
        logic [4:0]  wbrd;
        logic        fl;
        logic        ready;
        logic        stall;
        logic [31:0] busy;
        logic        err;
    } vec_t;

    vec_t vecs[$];

    rs_scoreboard #(.CNT_W(2), .WB_BYPASS(1)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .issue_valid    (issue_valid),
        .issue_ready    (issue_ready),
        .issue_rs1      (issue_rs1),
        .issue_rs2      (issue_rs2),
        .issue_uses_rs1 (issue_uses_rs1),
        .issue_uses_rs2 (issue_uses_rs2),
        .issue_rd       (issue_rd),
        .issue_rd_we    (issue_rd_we),
        .wb_valid       (wb_valid),
        .wb_rd          (wb_rd),
        .flush          (flush),
        .busy_vec       (busy_vec),
        .stall          (stall),
        .err_underflow  (err_underflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic vec_t mk(
        input logic v, input logic [4:0] rs1, input logic u1,
        input logic [4:0] rs2, input logic u2, input logic [4:0] rd, input logic we,
        input logic wbv, input logic [4:0] wbrd, input logic fl,
        input logic ready, input logic stl, input logic [31:0] busy, input logic err);
        vec_t t;
        t.v = v; t.rs1 = rs1; t.u1 = u1; t.rs2 = rs2; t.u2 = u2;
        t.rd = rd; t.we = we; t.wbv = wbv; t.wbrd = wbrd; t.fl = fl;
        t.ready = ready; t.stall = stl; t.busy = busy; t.err = err;
        return t;
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", name, actual, expected);
        end
    endtask

    task automatic drive(input vec_t t);
        issue_valid    = t.v;
        issue_rs1      = t.rs1;
        issue_uses_rs1 = t.u1;
        issue_rs2      = t.rs2;
        issue_uses_rs2 = t.u2;
        issue_rd       = t.rd;
        issue_rd_we    = t.we;
        wb_valid       = t.wbv;
        wb_rd          = t.wbrd;
        flush          = t.fl;
    endtask

    // Inputs change mid-cycle; outputs are sampled 1ns later, well clear of the rising edge
    task automatic applyStimulus(input vec_t t, input int idx);
        @(negedge clk);
        drive(t);
        #1;
        checkOutput($sformatf("v%0d.issue_ready", idx), 32'(issue_ready), 32'(t.ready));
        checkOutput($sformatf("v%0d.stall", idx), 32'(stall), 32'(t.stall));
        checkOutput($sformatf("v%0d.busy_vec", idx), busy_vec, t.busy);
        checkOutput($sformatf("v%0d.err_underflow", idx), 32'(err_underflow), 32'(t.err));
    endtask

    initial begin
        checks   = 0;
        failures = 0;

        //            v  rs1 u1 rs2 u2 rd we wbv wbrd fl  rdy stl busy          err
        // Basic RAW with writeback bypass
        vecs.push_back(mk(1, 0, 0, 0, 0, 5, 1, 0, 0, 0,  1, 0, 32'h0000_0000, 0));
        vecs.push_back(mk(1, 5, 1, 0, 0, 0, 0, 0, 0, 0,  0, 1, 32'h0000_0020, 0));
        vecs.push_back(mk(1, 5, 1, 0, 0, 0, 0, 1, 5, 0,  1, 0, 32'h0000_0020, 0));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0,  1, 0, 32'h0000_0000, 0));
        // x0 handling
        vecs.push_back(mk(1, 0, 0, 0, 0, 0, 1, 0, 0, 0,  1, 0, 32'h0000_0000, 0));
        vecs.push_back(mk(1, 0, 1, 0, 1, 0, 0, 0, 0, 0,  1, 0, 32'h0000_0000, 0));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 1, 0, 0,  1, 0, 32'h0000_0000, 0));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0,  1, 0, 32'h0000_0000, 0));
        // WAW saturation on x7: fourth writer waits for a writeback
        vecs.push_back(mk(1, 0, 0, 0, 0, 7, 1, 0, 0, 0,  1, 0, 32'h0000_0000, 0));
        vecs.push_back(mk(1, 0, 0, 0, 0, 7, 1, 0, 0, 0,  1, 0, 32'h0000_0080, 0));
        vecs.push_back(mk(1, 0, 0, 0, 0, 7, 1, 0, 0, 0,  1, 0, 32'h0000_0080, 0));
        vecs.push_back(mk(1, 0, 0, 0, 0, 7, 1, 0, 0, 0,  0, 1, 32'h0000_0080, 0));
        vecs.push_back(mk(1, 0, 0, 0, 0, 7, 1, 1, 7, 0,  0, 1, 32'h0000_0080, 0));
        vecs.push_back(mk(1, 0, 0, 0, 0, 7, 1, 0, 0, 0,  1, 0, 32'h0000_0080, 0));
        vecs.push_back(mk(1, 0, 0, 0, 0, 7, 1, 0, 0, 0,  0, 1, 32'h0000_0080, 0));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 1, 7, 0,  1, 0, 32'h0000_0080, 0));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 1, 7, 0,  1, 0, 32'h0000_0080, 0));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 1, 7, 0,  1, 0, 32'h0000_0080, 0));
        vecs.push_back(mk(1, 0, 0, 7, 1, 0, 0, 0, 0, 0,  1, 0, 32'h0000_0000, 0));
        // Simultaneous issue and writeback to x9 leaves the count at 1
        vecs.push_back(mk(1, 0, 0, 0, 0, 9, 1, 0, 0, 0,  1, 0, 32'h0000_0000, 0));
        vecs.push_back(mk(1, 0, 0, 0, 0, 9, 1, 1, 9, 0,  1, 0, 32'h0000_0200, 0));
        vecs.push_back(mk(1, 9, 1, 0, 0, 0, 0, 0, 0, 0,  0, 1, 32'h0000_0200, 0));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 1, 9, 0,  1, 0, 32'h0000_0200, 0));
        vecs.push_back(mk(1, 9, 1, 0, 0, 0, 0, 0, 0, 0,  1, 0, 32'h0000_0000, 0));
        // Flush with cnt[3]=2, cnt[12]=1 and a competing issue
        vecs.push_back(mk(1, 0, 0, 0, 0, 3, 1, 0, 0, 0,  1, 0, 32'h0000_0000, 0));
        vecs.push_back(mk(1, 0, 0, 0, 0, 3, 1, 0, 0, 0,  1, 0, 32'h0000_0008, 0));
        vecs.push_back(mk(1, 0, 0, 0, 0,12, 1, 0, 0, 0,  1, 0, 32'h0000_0008, 0));
        vecs.push_back(mk(1, 3, 1, 0, 0, 5, 1, 0, 0, 1,  0, 1, 32'h0000_1008, 0));
        vecs.push_back(mk(1, 3, 1, 0, 0, 0, 0, 0, 0, 0,  1, 0, 32'h0000_0000, 0));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0,  1, 0, 32'h0000_0000, 0));
        // Underflow on x4 is sticky
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 1, 4, 0,  1, 0, 32'h0000_0000, 0));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0,  1, 0, 32'h0000_0000, 1));
        vecs.push_back(mk(1, 0, 0, 0, 0, 6, 1, 0, 0, 0,  1, 0, 32'h0000_0000, 1));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0,  1, 0, 32'h0000_0040, 1));
        // Source-use enables: rs2 hazard stalls, unused sources do not
        vecs.push_back(mk(1, 6, 0, 6, 1, 0, 0, 0, 0, 0,  0, 1, 32'h0000_0040, 1));
        vecs.push_back(mk(1, 6, 0, 6, 0, 0, 0, 0, 0, 0,  1, 0, 32'h0000_0040, 1));

        // Reset state, including readiness gated by flush
        rst_n = 1'b0;
        drive(mk(1, 5, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 32'h0, 0));
        #12;
        checkOutput("reset.busy_vec", busy_vec, 32'h0);
        checkOutput("reset.err_underflow", 32'(err_underflow), 32'h0);
        checkOutput("reset.issue_ready", 32'(issue_ready), 32'h1);
        checkOutput("reset.stall", 32'(stall), 32'h0);
        flush = 1'b1;
        #1;
        checkOutput("reset.ready_flush", 32'(issue_ready), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < vecs.size(); i++) begin
            applyStimulus(vecs[i], i);
        end

        // Asynchronous reset mid-stream with x6 pending and the error flag set
        @(negedge clk);
        drive(mk(1, 6, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 32'h0, 0));
        #1;
        checkOutput("pre_rst.stall", 32'(stall), 32'h1);
        #1;
        rst_n = 1'b0;
        #1;
        checkOutput("async_rst.busy_vec", busy_vec, 32'h0);
        checkOutput("async_rst.err_underflow", 32'(err_underflow), 32'h0);
        checkOutput("async_rst.issue_ready", 32'(issue_ready), 32'h1);
        checkOutput("async_rst.stall", 32'(stall), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        #1;
        checkOutput("post_rst.busy_vec", busy_vec, 32'h0);
        checkOutput("post_rst.stall", 32'(stall), 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/rs_scoreboard.md
# rs_scoreboard

Register scoreboard for the in-order RISC-V pipeline. It keeps an outstanding-write count for each of the 32 architectural registers. It holds an instruction at issue while any source register it reads (rs1, rs2) still has a write in flight, or while its destination counter is saturated. Writebacks from the execute/memory stages release the counters. It sits between decode and the register-file read stage, and its issue handshake is the pipeline's stall source.

## Interface
- `CNT_W`, default 2: width of each per-register pending counter; maximum pending writes per register is 2^CNT_W-1.
- `WB_BYPASS`, default 1: when 1, a writeback in the same cycle releases a source hazard combinationally (see Timing).
- `clk` input, 1 bit: clock; all state updates on the rising edge.
- `rst_n` input, 1 bit: reset, asynchronous, active-low.
- `issue_valid` input, 1 bit: decode presents an instruction.
- `issue_ready` output, 1 bit: the instruction may issue this cycle.
- `issue_rs1` input, 5 bits: source register 1 address.
- `issue_rs2` input, 5 bits: source register 2 address.
- `issue_uses_rs1` input, 1 bit: the instruction reads rs1.
- `issue_uses_rs2` input, 1 bit: the instruction reads rs2.
- `issue_rd` input, 5 bits: destination register address.
- `issue_rd_we` input, 1 bit: the instruction writes rd.
- `wb_valid` input, 1 bit: a register write completes this cycle.
- `wb_rd` input, 5 bits: address of the completed write.
- `flush` input, 1 bit: pipeline flush; clears all pending state.
- `busy_vec` output, 32 bits: bit i = (cnt[i] != 0), registered.
- `stall` output, 1 bit: issue_valid & !issue_ready.
- `err_underflow` output, 1 bit: sticky flag, set when a writeback targets a register whose count is 0.

## Operation
- State: cnt[0..31], each CNT_W bits, plus the err_underflow flag.
- Register x0 never becomes busy:
  - issue with rd==0 does not increment;
  - wb_rd==0 is ignored and does not set err_underflow.
- The instruction fires when fire = issue_valid & issue_ready.
- issue_ready = !flush & !haz1 & !haz2 & !waw_full.
  - haz1 = issue_uses_rs1 & rs1!=0 & eff_busy(rs1)
  - haz2 = issue_uses_rs2 & rs2!=0 & eff_busy(rs2)
  - waw_full = issue_rd_we & rd!=0 & cnt[rd]==max
- eff_busy(r):
  - WB_BYPASS=1: cnt[r]!=0 & !(wb_valid & wb_rd==r & cnt[r]==1).
  - WB_BYPASS=0: cnt[r]!=0.
- Counter update per register r, next cycle:
  - inc = fire & issue_rd_we & issue_rd==r & r!=0
  - dec = wb_valid & wb_rd==r & r!=0 & cnt[r]!=0
  - inc & dec: unchanged; inc only: +1; dec only: -1.
  - Counters never wrap, guaranteed by waw_full and the dec guard.
- Underflow: wb_valid & wb_rd!=0 & cnt[wb_rd]==0 sets err_underflow. It is cleared only by reset.
- Flush:
  - all cnt are 0 on the next edge;
  - flush has priority over same-cycle issue and writeback;
  - issue_ready=0 during the flush cycle.
- issue_ready does not depend on issue_valid, so there is no valid/ready combinational loop.

## Timing
- Reset, asynchronous: all cnt=0, busy_vec=0, err_underflow=0.
- After reset, issue_ready = !flush and stall = 0.
- Reset asserted mid-operation discards all pending state immediately.
- Issue-to-busy latency: a fire on edge N makes busy_vec[rd] visible after edge N. A dependent instruction in cycle N+1 stalls.
- Writeback-to-release:
  - WB_BYPASS=1: the dependent instruction issues in the same cycle as the final writeback.
  - WB_BYPASS=0: it issues one cycle later.
- Back-to-back issues to the same rd accumulate up to the maximum (3 at CNT_W=2). The next writer to that rd stalls until a writeback.
- The issue_ready path is combinational from cnt, wb_*, issue_* and flush. busy_vec and err_underflow are registered.

## Test plan
- **Basic RAW:** issue rd=5, we=1. Next cycle issue rs1=5, uses_rs1=1 -> stall=1, busy_vec=0x20. Then wb_rd=5 -> with WB_BYPASS=1 the dependent issues in that cycle and busy_vec=0 next cycle.
- **x0 handling:** issue rd=0, then rs1=0 -> no stall, busy_vec stays 0. wb_rd=0 with cnt empty -> err_underflow stays 0.
- **WAW saturation:** 3 issues to rd=7 -> cnt[7]=3 and a 4th issue to rd=7 stalls. One wb_rd=7 -> the 4th issues and cnt[7] returns to 3.
- **Simultaneous issue and writeback to the same rd:** cnt[9]=1, fire with rd=9 plus wb_rd=9 in the same cycle -> cnt[9]=1, busy_vec[9]=1.
- **Flush:** cnt[3]=2 and cnt[12]=1, assert flush together with issue_valid -> issue_ready=0 that cycle, then busy_vec=0 and rs1=3 issues with no stall.
- **Underflow and reset:** wb_rd=4 with cnt[4]=0 -> err_underflow=1 and stays set. Asserting rst_n=0 mid-stream -> all outputs return to their reset values asynchronously.
